// File: rtl/game_sequencer.sv
// game_sequencer: BlockyRoads game-state FSM with one-hot status, per-frame road scroll and saturating score.
module game_sequencer #(
  parameter int ROAD_ROWS   = 310,
  parameter int SCROLL_DIV  = 1,
  parameter int LOAD_FRAMES = 60,
  parameter int TERM_FRAMES = 180
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       crash,
  output logic [3:0] status,
  output logic [8:0] scroll,
  output logic [15:0] score
);
  localparam int TMAX = LOAD_FRAMES > TERM_FRAMES ? LOAD_FRAMES : TERM_FRAMES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int DW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
  typedef enum logic [2:0] {S_NONE, S_LOAD, S_ACT, S_PAUSE, S_TERM} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [8:0] scroll_q, scroll_d;
  logic [15:0] score_q, score_d;
  logic [3:0] status_q, status_d;
  logic start_prev_q, pause_prev_q;
  logic start_e, pause_e;
  assign start_e = start_btn & ~start_prev_q;
  assign pause_e = pause_btn & ~pause_prev_q;
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    div_d    = div_q;
    scroll_d = scroll_q;
    score_d  = score_q;
    case (state_q)
      S_NONE: if (frame_tick) begin
        state_d = S_LOAD;
        timer_d = '0;
      end
      S_LOAD: if (start_e && timer_q == TW'(LOAD_FRAMES)) begin
        state_d  = S_ACT;
        scroll_d = '0;
        score_d  = '0;
        div_d    = '0;
      end else if (frame_tick && timer_q != TW'(LOAD_FRAMES)) timer_d = timer_q + 1'b1;
      S_ACT: if (crash) begin
        state_d = S_TERM;
        timer_d = '0;
      end else if (pause_e) state_d = S_PAUSE;
      else if (frame_tick) begin
        score_d = score_q == 16'hFFFF ? score_q : score_q + 16'd1;
        div_d   = div_q == DW'(SCROLL_DIV - 1) ? '0 : div_q + 1'b1;
        if (div_q == DW'(SCROLL_DIV - 1)) scroll_d = scroll_q == 9'd0 ? 9'(ROAD_ROWS - 1) : scroll_q - 9'd1;
      end
      S_PAUSE: if (pause_e || start_e) state_d = S_ACT;
      S_TERM: if (start_e || (frame_tick && timer_q == TW'(TERM_FRAMES - 1))) begin
        state_d = S_LOAD;
        timer_d = '0;
      end else if (frame_tick) timer_d = timer_q + 1'b1;
      default: state_d = S_NONE;
    endcase
    status_d = state_d == S_LOAD  ? 4'b1000 :
               state_d == S_ACT   ? 4'b0100 :
               state_d == S_PAUSE ? 4'b0010 :
               state_d == S_TERM  ? 4'b0001 : 4'b0000;
  end
  // Button history resets high so a button held through reset yields no edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= S_NONE;
      timer_q      <= '0;
      div_q        <= '0;
      scroll_q     <= '0;
      score_q      <= '0;
      status_q     <= '0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      div_q        <= div_d;
      scroll_q     <= scroll_d;
      score_q      <= score_d;
      status_q     <= status_d;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
    end
  end
  assign status = status_q;
  assign scroll = scroll_q;
  assign score  = score_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed vectors for game_sequencer; a second instance with SCROLL_DIV=2 shares all inputs.
module tb_game_sequencer;
  logic clk = 0, clr = 0, frame_tick = 0, start_btn = 0, pause_btn = 0, crash = 0;
  logic [3:0] status, status_b;
  logic [8:0] scroll, scroll_b;
  logic [15:0] score, score_b;
  int n_chk = 0, n_err = 0;
  game_sequencer dut (.clk(clk), .clr(clr), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .crash(crash), .status(status), .scroll(scroll), .score(score));
  game_sequencer #(.SCROLL_DIV(2)) dut_b (.clk(clk), .clr(clr), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .crash(crash), .status(status_b), .scroll(scroll_b), .score(score_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic ft);
    frame_tick = ft;
    @(posedge clk);
    #1;
    frame_tick = 0;
  endtask
  task automatic ticks(input int n);
    repeat (n) cyc(1);
  endtask
  task automatic press_start;
    start_btn = 1;
    cyc(0);
    start_btn = 0;
  endtask
  task automatic press_pause;
    pause_btn = 1;
    cyc(0);
    pause_btn = 0;
  endtask
  initial begin
    #12;
    chk("rst_status", status, 4'b0000);
    chk("rst_scroll", scroll, 0);
    chk("rst_score", score, 0);
    #11 clr = 1;
    @(posedge clk); #1;
    cyc(0);
    chk("none_idle", status, 4'b0000);
    cyc(1);
    chk("load_entry", status, 4'b1000);
    ticks(10);
    press_start;
    cyc(0);
    chk("early_start", status, 4'b1000);
    ticks(50);
    press_start;
    chk("act_entry", status, 4'b0100);
    chk("act_scroll0", scroll, 0);
    chk("act_score0", score, 0);
    chk("b_act_entry", status_b, 4'b0100);
    cyc(1);
    chk("scr1", scroll, 309); chk("sc1", score, 1); chk("b_scr1", scroll_b, 0);
    cyc(1);
    chk("scr2", scroll, 308); chk("sc2", score, 2); chk("b_scr2", scroll_b, 309);
    cyc(1);
    chk("scr3", scroll, 307); chk("sc3", score, 3); chk("b_scr3", scroll_b, 309);
    cyc(1);
    chk("b_scr4", scroll_b, 308); chk("scr4", scroll, 306);
    press_pause;
    chk("pause", status, 4'b0010);
    ticks(5);
    chk("pause_scroll", scroll, 306);
    chk("pause_score", score, 4);
    press_pause;
    chk("resume", status, 4'b0100);
    cyc(1);
    chk("resume_scroll", scroll, 305);
    chk("resume_score", score, 5);
    chk("b_resume_scroll", scroll_b, 308);
    crash = 1; pause_btn = 1;
    cyc(1);
    crash = 0; pause_btn = 0;
    chk("crash_status", status, 4'b0001);
    chk("crash_score", score, 5);
    chk("crash_scroll", scroll, 305);
    ticks(179);
    chk("term_179", status, 4'b0001);
    chk("term_hold_score", score, 5);
    cyc(1);
    chk("term_180", status, 4'b1000);
    start_btn = 1;
    #2 clr = 0;
    #1;
    chk("async_rst_status", status, 4'b0000);
    @(negedge clk) clr = 1;
    @(posedge clk); #1;
    cyc(1);
    chk("held_load", status, 4'b1000);
    ticks(60);
    cyc(0);
    chk("held_no_edge", status, 4'b1000);
    start_btn = 0;
    cyc(0);
    press_start;
    chk("act2", status, 4'b0100);
    ticks(2);
    chk("act2_score", score, 2);
    #2 clr = 0;
    #1;
    chk("mid_rst_status", status, 4'b0000);
    chk("mid_rst_scroll", scroll, 0);
    chk("mid_rst_score", score, 0);
    @(negedge clk) clr = 1;
    @(posedge clk); #1;
    cyc(1);
    ticks(60);
    press_start;
    chk("act3", status, 4'b0100);
    frame_tick = 1;
    repeat (65534) @(posedge clk);
    #1;
    frame_tick = 0;
    chk("score_fffe", score, 16'hFFFE);
    cyc(1);
    chk("sat1", score, 16'hFFFF);
    cyc(1);
    chk("sat2", score, 16'hFFFF);
    cyc(1);
    chk("sat3", score, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
